// File: rtl/id_stage_pkg.sv
// Shared decode constants, imm-op encodings and buffer types for the decode stage.
// The immediate generator uses the same IMM_* encodings and opcode constants.
package id_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned IMM_OP_W = 3;
  localparam int unsigned OPC_W    = 7;
  // Low instruction bits the decoder looks at (opcode..rs2).
  localparam int unsigned DEC_IN_W = 25;

  localparam logic [IMM_OP_W-1:0] IMM_I  = 3'b000;
  localparam logic [IMM_OP_W-1:0] IMM_S  = 3'b001;
  localparam logic [IMM_OP_W-1:0] IMM_B  = 3'b010;
  localparam logic [IMM_OP_W-1:0] IMM_U  = 3'b011;
  localparam logic [IMM_OP_W-1:0] IMM_J  = 3'b100;
  localparam logic [IMM_OP_W-1:0] IMM_C  = 3'b101;
  localparam logic [IMM_OP_W-1:0] IMM_SH = 3'b110;

  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [IMM_OP_W-1:0] imm_op;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [REG_AW-1:0]   rd;
    logic                rf_we;
    logic                illegal;
  } dec_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    dec_t            dec;
  } entry_t;

endpackage

// File: rtl/insn_decoder.sv
// Combinational instruction decode: imm-op select, register indices, write enable.
// Unknown-opcode flagging is enabled by ID_ILLEGAL_CHECK_EN.
module insn_decoder
  import id_stage_pkg::*;
(
  input  logic [DEC_IN_W-1:0] instr_i,
  output dec_t                dec_o
);

  logic [OPC_W-1:0] opcode;
  logic [2:0]       funct3;

  assign opcode = instr_i[OPC_W-1:0];
  assign funct3 = instr_i[14:12];

  always_comb begin
    dec_o        = '0;
    dec_o.imm_op = IMM_I;
    dec_o.rs1    = instr_i[19:15];
    dec_o.rs2    = instr_i[24:20];
    dec_o.rd     = instr_i[11:7];
    case (opcode)
      OPC_OP_IMM: begin
        dec_o.imm_op = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
        dec_o.rf_we  = 1'b1;
      end
      OPC_LOAD, OPC_JALR, OPC_OP: dec_o.rf_we = 1'b1;
      OPC_STORE:  dec_o.imm_op = IMM_S;
      OPC_BRANCH: dec_o.imm_op = IMM_B;
      OPC_LUI, OPC_AUIPC: begin
        dec_o.imm_op = IMM_U;
        dec_o.rf_we  = 1'b1;
      end
      OPC_JAL: begin
        dec_o.imm_op = IMM_J;
        dec_o.rf_we  = 1'b1;
      end
      OPC_SYSTEM: begin
        dec_o.imm_op = funct3[2] ? IMM_C : IMM_I;
        dec_o.rf_we  = 1'b1;
      end
      default: begin
`ifdef ID_ILLEGAL_CHECK_EN
        dec_o.illegal = 1'b1;
`endif
      end
    endcase
    // x0 is never written.
    if (dec_o.rd == '0) dec_o.rf_we = 1'b0;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: 2-entry skid buffer (main + skid) holding instructions decoded at accept.
// Optional macro ID_ILLEGAL_CHECK_EN enables illegal-opcode flagging in the decoder.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_valid_i,
  output logic                if_ready_o,
  input  logic [XLEN-1:0]     if_instr_i,
  input  logic [XLEN-1:0]     if_pc_i,
  input  logic                flush_i,
  output logic                id_valid_o,
  input  logic                id_ready_i,
  output logic [XLEN-1:0]     id_instr_o,
  output logic [XLEN-1:0]     id_pc_o,
  output logic [IMM_OP_W-1:0] id_imm_op_o,
  output logic [REG_AW-1:0]   id_rs1_o,
  output logic [REG_AW-1:0]   id_rs2_o,
  output logic [REG_AW-1:0]   id_rd_o,
  output logic                id_rf_we_o,
  output logic                id_illegal_o
);

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   valid_q, valid_d;
  logic   ready_q, ready_d;

  dec_t   in_dec;
  entry_t in_entry;
  logic   accept;
  logic   xfer;

  insn_decoder u_dec (
    .instr_i (if_instr_i[DEC_IN_W-1:0]),
    .dec_o   (in_dec)
  );

  always_comb begin
    in_entry       = '0;
    in_entry.instr = if_instr_i;
    in_entry.pc    = if_pc_i;
    in_entry.dec   = in_dec;
  end

  assign accept = if_valid_i && ready_q;
  assign xfer   = valid_q && id_ready_i;

  // Next-state: flush wins over every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !xfer) begin
            skid_d  = in_entry;
            state_d = ST_TWO;
          end else if (xfer && !accept) begin
            state_d = ST_EMPTY;
          end else if (xfer && accept) begin
            main_d  = in_entry;
          end
        end
        ST_TWO: begin
          if (xfer) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign if_ready_o   = ready_q;
  assign id_valid_o   = valid_q;
  assign id_instr_o   = main_q.instr;
  assign id_pc_o      = main_q.pc;
  assign id_imm_op_o  = main_q.dec.imm_op;
  assign id_rs1_o     = main_q.dec.rs1;
  assign id_rs2_o     = main_q.dec.rs2;
  assign id_rd_o      = main_q.dec.rd;
  assign id_rf_we_o   = main_q.dec.rf_we;
  assign id_illegal_o = main_q.dec.illegal;

endmodule
